// File: rtl/tmr_resync_scheduler_if.sv
// Register-file scrub port shared by the resync scheduler (master) and the three core RFs (slave).
// The pipeline's write-port ownership flag travels with it because it arbitrates the same write port.
interface tmr_resync_scheduler_if;
    logic        pipe_wr_busy;
    logic [31:0] rf_rd_data;
    logic [1:0]  rf_rd_core;
    logic [4:0]  rf_rd_addr;
    logic        rf_wr_en;
    logic [1:0]  rf_wr_core;
    logic [4:0]  rf_wr_addr;
    logic [31:0] rf_wr_data;

    modport master (
        input  pipe_wr_busy, rf_rd_data,
        output rf_rd_core, rf_rd_addr, rf_wr_en, rf_wr_core, rf_wr_addr, rf_wr_data
    );

    modport slave (
        output pipe_wr_busy, rf_rd_data,
        input  rf_rd_core, rf_rd_addr, rf_wr_en, rf_wr_core, rf_wr_addr, rf_wr_data
    );
endinterface

// File: rtl/tmr_resync_scheduler.sv
// TMR resync scheduler: on a single-core vote loss, holds all cores and copies x1..x31 from a healthy core.
// Optional macro SCRUB_VERIFY_EN adds a readback check (one rewrite, then fatal) after every scrub write.
module tmr_resync_scheduler #(
    parameter int DRAIN_CYCLES = 4,
    parameter int FAULT_THRESH = 3,
    parameter int CNT_W        = 4
) (
    input  logic                 clk,
    input  logic                 rst_in,
    input  logic [2:0]           voter_state,
    input  logic                 voter_valid,
    tmr_resync_scheduler_if.master rf,
    output logic                 core_hold,
    output logic                 scrub_active,
    output logic [3*CNT_W-1:0]   fault_count,
    output logic [2:0]           core_disabled,
    output logic                 fatal
);

    localparam int DW = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, DRAIN, READ, WRITE, VERIFY, DONE} state_t;

    state_t                  state_q, state_d;
    logic [DW-1:0]           cnt_q, cnt_d;
    logic [4:0]              idx_q, idx_d;
    logic [31:0]             data_q, data_d;
    logic [1:0]              src_q, src_d;
    logic [1:0]              tgt_q, tgt_d;
    logic [2:0][CNT_W-1:0]   fc_q, fc_d;
    logic [2:0]              dis_q, dis_d;
    logic                    fatal_q, fatal_d;
    logic                    hold_q, hold_d;
    logic                    single;
    logic [1:0]              f_idx;
    logic [CNT_W-1:0]        cnt_inc;
`ifdef SCRUB_VERIFY_EN
    logic                    retry_q, retry_d;
`endif

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            src_q   <= '0;
            tgt_q   <= '0;
            fc_q    <= '0;
            dis_q   <= '0;
            fatal_q <= 1'b0;
            hold_q  <= 1'b0;
`ifdef SCRUB_VERIFY_EN
            retry_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            src_q   <= src_d;
            tgt_q   <= tgt_d;
            fc_q    <= fc_d;
            dis_q   <= dis_d;
            fatal_q <= fatal_d;
            hold_q  <= hold_d;
`ifdef SCRUB_VERIFY_EN
            retry_q <= retry_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        data_d  = data_q;
        src_d   = src_q;
        tgt_d   = tgt_q;
        fc_d    = fc_q;
        dis_d   = dis_q;
        fatal_d = fatal_q;
`ifdef SCRUB_VERIFY_EN
        retry_d = retry_q;
`endif
        rf.rf_rd_core = 2'd0;
        rf.rf_rd_addr = 5'd0;
        rf.rf_wr_en   = 1'b0;
        rf.rf_wr_core = 2'd0;
        rf.rf_wr_addr = 5'd0;
        rf.rf_wr_data = 32'd0;
        single = 1'b0;
        f_idx  = 2'd0;

        case (voter_state)
            3'b110:  begin single = 1'b1; f_idx = 2'd0; end
            3'b101:  begin single = 1'b1; f_idx = 2'd1; end
            3'b011:  begin single = 1'b1; f_idx = 2'd2; end
            default: ;
        endcase
        cnt_inc = (fc_q[f_idx] == '1) ? fc_q[f_idx] : fc_q[f_idx] + CNT_W'(1);

        case (state_q)
            IDLE: begin
                if (voter_valid && voter_state != 3'b111) begin
                    if (!single) begin
                        fatal_d = 1'b1;
                    end else begin
                        fc_d[f_idx] = cnt_inc;
                        // A disabled faulty core is simply counted; losing a second core leaves no majority.
                        if (!dis_q[f_idx]) begin
                            if (dis_q != 3'b000) begin
                                fatal_d = 1'b1;
                            end else if (cnt_inc >= CNT_W'(FAULT_THRESH)) begin
                                dis_d[f_idx] = 1'b1;
                            end else begin
                                state_d = DRAIN;
                                cnt_d   = '0;
                                tgt_d   = f_idx;
                                src_d   = (f_idx == 2'd0) ? 2'd1 : 2'd0;
                            end
                        end
                    end
                end
            end
            DRAIN: begin
                if (cnt_q == DW'(DRAIN_CYCLES - 1)) begin
                    state_d = READ;
                    idx_d   = 5'd1;
                end else begin
                    cnt_d = cnt_q + DW'(1);
                end
            end
            READ: begin
                rf.rf_rd_core = src_q;
                rf.rf_rd_addr = idx_q;
                data_d        = rf.rf_rd_data;
                state_d       = WRITE;
            end
            WRITE: begin
                rf.rf_wr_core = tgt_q;
                rf.rf_wr_addr = idx_q;
                rf.rf_wr_data = data_q;
                if (!rf.pipe_wr_busy) begin
                    rf.rf_wr_en = 1'b1;
`ifdef SCRUB_VERIFY_EN
                    state_d = VERIFY;
`else
                    if (idx_q == 5'd31) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 5'd1;
                        state_d = READ;
                    end
`endif
                end
            end
`ifdef SCRUB_VERIFY_EN
            VERIFY: begin
                rf.rf_rd_core = tgt_q;
                rf.rf_rd_addr = idx_q;
                // First mismatch earns one rewrite; a second one is fatal but the scrub moves on.
                if (rf.rf_rd_data != data_q && !retry_q) begin
                    retry_d = 1'b1;
                    state_d = WRITE;
                end else begin
                    if (rf.rf_rd_data != data_q) fatal_d = 1'b1;
                    retry_d = 1'b0;
                    if (idx_q == 5'd31) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 5'd1;
                        state_d = READ;
                    end
                end
            end
`endif
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        hold_d = (state_d != IDLE);
    end

    assign core_hold     = hold_q;
    assign scrub_active  = hold_q;
    assign fault_count   = fc_q;
    assign core_disabled = dis_q;
    assign fatal         = fatal_q;

endmodule

// File: tb/tb_tmr_resync_scheduler.sv
// Directed bench for tmr_resync_scheduler with a three-core register-file model on the scrub port.
// Builds with or without SCRUB_VERIFY_EN; the readback-corruption scenario only exists in the verify build.
module tb_tmr_resync_scheduler;

    localparam int DRAIN = 4;
`ifdef SCRUB_VERIFY_EN
    localparam int PER_REG = 3;
`else
    localparam int PER_REG = 2;
`endif
    localparam int LAT = 1 + DRAIN + 31 * PER_REG + 1;

    logic        clk = 1'b0;
    logic        rst_in;
    logic [2:0]  voter_state;
    logic        voter_valid;
    logic        core_hold;
    logic        scrub_active;
    logic [11:0] fault_count;
    logic [2:0]  core_disabled;
    logic        fatal;

    tmr_resync_scheduler_if sif ();

    tmr_resync_scheduler #(
        .DRAIN_CYCLES (DRAIN),
        .FAULT_THRESH (3),
        .CNT_W        (4)
    ) dut (
        .clk           (clk),
        .rst_in        (rst_in),
        .voter_state   (voter_state),
        .voter_valid   (voter_valid),
        .rf            (sif.master),
        .core_hold     (core_hold),
        .scrub_active  (scrub_active),
        .fault_count   (fault_count),
        .core_disabled (core_disabled),
        .fatal         (fatal)
    );

    always #5 clk = ~clk;

    logic [31:0] rf_mem [3][32];
    logic [31:0] rd_model;
    int          corrupt_left;

    // Combinational RF read; while corrupt_left is nonzero the target core's x7 readback is flipped.
    always_comb begin
        rd_model = 32'd0;
        if (sif.rf_rd_core != 2'd3) rd_model = rf_mem[sif.rf_rd_core][sif.rf_rd_addr];
        if (corrupt_left > 0 && sif.rf_rd_core == 2'd1 && sif.rf_rd_addr == 5'd7)
            rd_model = rd_model ^ 32'hDEAD_BEEF;
    end
    assign sif.rf_rd_data = rd_model;

    int errors;
    int checks;
    int exp_src;
    logic [1:0] exp_tgt;
    int cycles, wr_total, data_bad, core_bad, busy_viol, stall_cycles, activity;
    int hits [32];
    logic hold_at_1;

    function automatic logic [31:0] init_val(input int c, input int n);
        if (c == 0) return n * 17;
        if (c == 1) return 32'hA000_0000 | n;
        return 32'hB000_0000 | n;
    endfunction

    task automatic load_rf();
        for (int c = 0; c < 3; c++)
            for (int n = 0; n < 32; n++)
                rf_mem[c][n] = init_val(c, n);
    endtask

    task automatic reset_dut();
        rst_in = 1'b0;
        voter_valid = 1'b0;
        voter_state = 3'b111;
        sif.pipe_wr_busy = 1'b0;
        corrupt_left = 0;
        load_rf();
        @(negedge clk);
        @(negedge clk);
        rst_in = 1'b1;
        @(negedge clk);
    endtask

    // Leaves the caller at the falling edge of the first cycle after the sampled pulse.
    task automatic pulse_voter(input logic [2:0] vs);
        @(negedge clk);
        voter_state = vs;
        voter_valid = 1'b1;
        @(negedge clk);
        voter_valid = 1'b0;
        voter_state = 3'b111;
    endtask

    task automatic watch_idle(input int n);
        activity = 0;
        repeat (n) begin
            @(negedge clk);
            if (core_hold || scrub_active || sif.rf_wr_en) activity++;
        end
    endtask

    // Runs a scrub to completion, recording writes; optionally stalls idx 5 or fires a stray vote.
    task automatic run_scrub(input bit inject_busy, input bit inject_voter);
        int  busy_left;
        bit  armed;
        bit  seen7;
        busy_left = 0;
        armed = inject_busy;
        seen7 = 1'b0;
        cycles = 1;
        wr_total = 0; data_bad = 0; core_bad = 0; busy_viol = 0; stall_cycles = 0;
        for (int i = 0; i < 32; i++) hits[i] = 0;
        hold_at_1 = core_hold;
        while (core_hold && cycles < 400) begin
            if (armed && sif.rf_rd_core == 2'd0 && sif.rf_rd_addr == 5'd5) begin
                sif.pipe_wr_busy = 1'b1;
                busy_left = 4;
                armed = 1'b0;
            end else if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) sif.pipe_wr_busy = 1'b0;
            end
            if (inject_voter && cycles == 10) begin voter_state = 3'b011; voter_valid = 1'b1; end
            if (inject_voter && cycles == 11) begin voter_state = 3'b111; voter_valid = 1'b0; end
            if (seen7) begin corrupt_left--; seen7 = 1'b0; end
            if (corrupt_left > 0 && sif.rf_rd_core == 2'd1 && sif.rf_rd_addr == 5'd7) seen7 = 1'b1;
            #1;
            if (sif.rf_wr_en) begin
                wr_total++;
                hits[sif.rf_wr_addr]++;
                if (sif.rf_wr_data !== init_val(exp_src, int'(sif.rf_wr_addr))) data_bad++;
                if (sif.rf_wr_core !== exp_tgt) core_bad++;
                if (sif.pipe_wr_busy) busy_viol++;
                if (sif.rf_wr_core != 2'd3) rf_mem[sif.rf_wr_core][sif.rf_wr_addr] = sif.rf_wr_data;
            end else if (sif.pipe_wr_busy && sif.rf_wr_addr == 5'd5) begin
                stall_cycles++;
            end
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset();
        #1;
        checks++; if (core_hold !== 1'b0) begin errors++; $display("[TB] FAIL reset_hold: got %0b want 0", core_hold); end
        checks++; if (scrub_active !== 1'b0) begin errors++; $display("[TB] FAIL reset_active: got %0b want 0", scrub_active); end
        checks++; if (sif.rf_wr_en !== 1'b0 || sif.rf_rd_addr !== 5'd0) begin errors++; $display("[TB] FAIL reset_port: wr_en=%0b rd_addr=%0d want 0/0", sif.rf_wr_en, sif.rf_rd_addr); end
        checks++; if (fault_count !== 12'h000 || core_disabled !== 3'b000 || fatal !== 1'b0) begin errors++; $display("[TB] FAIL reset_status: cnt=%h dis=%b fatal=%b want 000/000/0", fault_count, core_disabled, fatal); end
        @(negedge clk);
        rst_in = 1'b1;
        pulse_voter(3'b101);
        @(negedge clk);
        @(negedge clk);
        checks++; if (core_hold !== 1'b1 || fault_count !== 12'h010) begin errors++; $display("[TB] FAIL drain_state: hold=%0b cnt=%h want 1/010", core_hold, fault_count); end
        #2;
        rst_in = 1'b0;
        #1;
        checks++; if (core_hold !== 1'b0 || scrub_active !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_hold: hold=%0b active=%0b want 0/0", core_hold, scrub_active); end
        checks++; if (fault_count !== 12'h000) begin errors++; $display("[TB] FAIL async_reset_cnt: got %h want 000", fault_count); end
        @(negedge clk);
        rst_in = 1'b1;
        pulse_voter(3'b111);
        watch_idle(8);
        checks++; if (activity !== 0) begin errors++; $display("[TB] FAIL post_reset_idle: got %0d active cycles want 0", activity); end
        checks++; if (fatal !== 1'b0 || fault_count !== 12'h000) begin errors++; $display("[TB] FAIL all_agree: fatal=%b cnt=%h want 0/000", fatal, fault_count); end
    endtask

    task automatic test_single_fault();
        int bad_addr;
        reset_dut();
        exp_src = 0;
        exp_tgt = 2'd1;
        pulse_voter(3'b101);
        run_scrub(1'b0, 1'b0);
        bad_addr = 0;
        for (int i = 1; i < 32; i++) if (hits[i] != 1) bad_addr++;
        checks++; if (hold_at_1 !== 1'b1) begin errors++; $display("[TB] FAIL hold_cycle1: got %0b want 1", hold_at_1); end
        checks++; if (cycles != LAT) begin errors++; $display("[TB] FAIL scrub_latency: got %0d want %0d", cycles, LAT); end
        checks++; if (wr_total != 31 || hits[0] != 0 || bad_addr != 0) begin errors++; $display("[TB] FAIL scrub_writes: total=%0d x0=%0d bad_addr=%0d want 31/0/0", wr_total, hits[0], bad_addr); end
        checks++; if (data_bad != 0 || core_bad != 0) begin errors++; $display("[TB] FAIL scrub_data: bad_data=%0d bad_core=%0d want 0/0", data_bad, core_bad); end
        checks++; if (fault_count !== 12'h010 || fatal !== 1'b0 || core_disabled !== 3'b000) begin errors++; $display("[TB] FAIL single_status: cnt=%h fatal=%b dis=%b want 010/0/000", fault_count, fatal, core_disabled); end
        checks++; if (scrub_active !== 1'b0 || sif.rf_wr_en !== 1'b0) begin errors++; $display("[TB] FAIL scrub_end: active=%0b wr_en=%0b want 0/0", scrub_active, sif.rf_wr_en); end
    endtask

    task automatic test_write_stall();
        pulse_voter(3'b101);
        run_scrub(1'b1, 1'b0);
        checks++; if (cycles != LAT + 3) begin errors++; $display("[TB] FAIL stall_latency: got %0d want %0d", cycles, LAT + 3); end
        checks++; if (stall_cycles != 3 || busy_viol != 0) begin errors++; $display("[TB] FAIL stall_cycles: stalled=%0d wr_while_busy=%0d want 3/0", stall_cycles, busy_viol); end
        checks++; if (hits[5] != 1 || wr_total != 31 || data_bad != 0) begin errors++; $display("[TB] FAIL stall_writes: x5=%0d total=%0d bad_data=%0d want 1/31/0", hits[5], wr_total, data_bad); end
        checks++; if (fault_count !== 12'h020) begin errors++; $display("[TB] FAIL stall_count: got %h want 020", fault_count); end
    endtask

    task automatic test_threshold();
        reset_dut();
        exp_src = 1;
        exp_tgt = 2'd0;
        for (int k = 0; k < 2; k++) begin
            pulse_voter(3'b110);
            run_scrub(1'b0, 1'b0);
            checks++; if (cycles != LAT || wr_total != 31) begin errors++; $display("[TB] FAIL thresh_scrub%0d: cycles=%0d writes=%0d want %0d/31", k, cycles, wr_total, LAT); end
            checks++; if (data_bad != 0 || core_bad != 0) begin errors++; $display("[TB] FAIL thresh_src%0d: bad_data=%0d bad_core=%0d want 0/0", k, data_bad, core_bad); end
        end
        checks++; if (fault_count !== 12'h002) begin errors++; $display("[TB] FAIL thresh_count2: got %h want 002", fault_count); end
        pulse_voter(3'b110);
        watch_idle(8);
        checks++; if (activity !== 0) begin errors++; $display("[TB] FAIL thresh_no_scrub: got %0d active cycles want 0", activity); end
        checks++; if (core_disabled !== 3'b001 || fault_count !== 12'h003 || fatal !== 1'b0) begin errors++; $display("[TB] FAIL thresh_disable: dis=%b cnt=%h fatal=%b want 001/003/0", core_disabled, fault_count, fatal); end
        pulse_voter(3'b101);
        @(negedge clk);
        checks++; if (fatal !== 1'b1 || core_hold !== 1'b0) begin errors++; $display("[TB] FAIL no_spare: fatal=%b hold=%b want 1/0", fatal, core_hold); end
        checks++; if (fault_count !== 12'h013 || core_disabled !== 3'b001) begin errors++; $display("[TB] FAIL no_spare_status: cnt=%h dis=%b want 013/001", fault_count, core_disabled); end
    endtask

    task automatic test_bad_vote();
        reset_dut();
        pulse_voter(3'b000);
        watch_idle(4);
        checks++; if (fatal !== 1'b1 || activity !== 0 || fault_count !== 12'h000) begin errors++; $display("[TB] FAIL vote_000: fatal=%b active=%0d cnt=%h want 1/0/000", fatal, activity, fault_count); end
        reset_dut();
        pulse_voter(3'b001);
        watch_idle(4);
        checks++; if (fatal !== 1'b1 || activity !== 0) begin errors++; $display("[TB] FAIL vote_001: fatal=%b active=%0d want 1/0", fatal, activity); end
        reset_dut();
        exp_src = 0;
        exp_tgt = 2'd1;
        pulse_voter(3'b101);
        run_scrub(1'b0, 1'b1);
        checks++; if (cycles != LAT || wr_total != 31) begin errors++; $display("[TB] FAIL ignore_vote_scrub: cycles=%0d writes=%0d want %0d/31", cycles, wr_total, LAT); end
        checks++; if (fault_count !== 12'h010 || fatal !== 1'b0) begin errors++; $display("[TB] FAIL ignore_vote_status: cnt=%h fatal=%b want 010/0", fault_count, fatal); end
    endtask

`ifdef SCRUB_VERIFY_EN
    task automatic test_verify();
        reset_dut();
        exp_src = 0;
        exp_tgt = 2'd1;
        corrupt_left = 2;
        pulse_voter(3'b101);
        run_scrub(1'b0, 1'b0);
        checks++; if (cycles != LAT + 2) begin errors++; $display("[TB] FAIL verify_latency: got %0d want %0d", cycles, LAT + 2); end
        checks++; if (hits[7] != 2 || wr_total != 32 || hits[31] != 1) begin errors++; $display("[TB] FAIL verify_writes: x7=%0d total=%0d x31=%0d want 2/32/1", hits[7], wr_total, hits[31]); end
        checks++; if (fatal !== 1'b1 || data_bad != 0) begin errors++; $display("[TB] FAIL verify_fatal: fatal=%b bad_data=%0d want 1/0", fatal, data_bad); end
    endtask
`endif

    initial begin
        errors = 0;
        checks = 0;
        rst_in = 1'b0;
        voter_valid = 1'b0;
        voter_state = 3'b111;
        sif.pipe_wr_busy = 1'b0;
        corrupt_left = 0;
        exp_src = 0;
        exp_tgt = 2'd0;
        load_rf();
        $display("[TB] starting tmr_resync_scheduler bench, expected scrub latency %0d", LAT);
        test_reset();
        test_single_fault();
        test_write_stall();
        test_threshold();
        test_bad_vote();
`ifdef SCRUB_VERIFY_EN
        test_verify();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tmr_resync_scheduler.md
Name: tmr_resync_scheduler

Overview:
- Scheduler that resynchronises a faulty core's register file after the voter outvotes a single core in the TMR RISC-V top.
- Holds all cores, then copies x1..x31 from a healthy core into the faulty core over the shared register-file scrub port.
- Tracks per-core fault counts and retires a core permanently once it reaches a threshold.
- Sits beside the lockstep/rollback control, driven by the same 3-bit voter state.

Parameters:
- DRAIN_CYCLES, 4: cycles core_hold is asserted before the first scrub read, to let in-flight writebacks drain.
- FAULT_THRESH, 3: fault count at which a core is disabled.
- CNT_W, 4: width of each per-core fault counter; FAULT_THRESH must be below 2^CNT_W.

Ports:
- clk  in  1  system clock
- rst_in  in  1  reset, asynchronous, active-low
- voter_state  in  3  bit i = 1 means core i agrees with the majority
- voter_valid  in  1  voter_state is valid this cycle, one pulse per retired instruction
- pipe_wr_busy  in  1  pipeline writeback owns the RF write port this cycle
- rf_rd_data  in  32  read data from the source core's RF, combinational from rf_rd_addr/rf_rd_core
- core_hold  out  1  stall all three cores
- scrub_active  out  1  scrub sequence in progress
- rf_rd_core  out  2  source core index
- rf_rd_addr  out  5  scrub read address
- rf_wr_en  out  1  scrub write strobe
- rf_wr_core  out  2  target (faulty) core index
- rf_wr_addr  out  5  scrub write address
- rf_wr_data  out  32  scrub write data
- fault_count  out  3*CNT_W  per-core saturating counters; core i occupies [i*CNT_W +: CNT_W]
- core_disabled  out  3  sticky per-core retirement flags
- fatal  out  1  sticky: no majority, or fault with no spare core left

Behaviour:
- Reset (rst_in low, async): FSM=IDLE; all outputs 0; counters and flags cleared. Reset mid-scrub aborts immediately, with no partial write after deassert.
- Classification, performed only in IDLE when voter_valid=1:
  - 3'b111: no action.
  - Exactly one zero bit (110, 101, 011): single fault on core f. Increment fault_count[f], saturating at 2^CNT_W-1.
  - Any other pattern: fatal <= 1; no scrub.
- Single-fault dispatch:
  - Core f already disabled: counter increments only; no scrub.
  - Any other core already disabled: fatal <= 1; no scrub.
  - Count reaches FAULT_THRESH: core_disabled[f] <= 1; no scrub.
  - Otherwise: go to DRAIN. Source = lowest-index core that is neither f nor disabled.
- FSM states: IDLE -> DRAIN -> READ -> WRITE -> (READ | DONE) -> IDLE.
- core_hold and scrub_active are registered: high from the cycle after the triggering voter_valid through DONE inclusive.
- DRAIN: counts DRAIN_CYCLES cycles, then goes to READ with idx=1.
- READ: rf_rd_core=src and rf_rd_addr=idx. Capture rf_rd_data into the data register at the clock edge.
- WRITE: rf_wr_en=1 and rf_wr_core/addr/data = f/idx/captured data, unless pipe_wr_busy=1.
  - If pipe_wr_busy=1: rf_wr_en=0 and stay in WRITE; the pipeline always wins.
  - After a write: if idx=31, go to DONE; else idx+1 and go to READ.
- x0 is never read or written. idx is 5-bit and never wraps past 31.
- Uncontended latency, from trigger voter_valid to IDLE: 1 + DRAIN_CYCLES + 62 + 1 cycles (68 with defaults).
- voter_valid is ignored outside IDLE.
- rf_wr_en is 0 in every state except WRITE.

Optional Feature:
- Macro SCRUB_VERIFY_EN.
- When defined: after each WRITE, a VERIFY state reads rf_rd_core=f, rf_rd_addr=idx and compares against the written data.
  - Mismatch: rewrite once.
  - Second mismatch: fatal <= 1, and scrub continues with the next register.
  - Uncontended scrub becomes 3 cycles per register.
- When undefined: no VERIFY state, no readback, 2 cycles per register.

Test Plan:
- Reset pulse mid-DRAIN: all outputs 0 asynchronously; after release, FSM is IDLE and voter_valid with 3'b111 produces no activity.
- voter_state=3'b101 pulse, src RF x_n = n*0x11, DRAIN_CYCLES=4:
  - core_hold=1 from cycle 1.
  - 31 writes to core 1, addr 1..31, data n*0x11.
  - fault_count core1=1.
  - core_hold=0 at cycle 68.
- pipe_wr_busy held high 3 cycles during the WRITE for idx=5: rf_wr_en low for those cycles; idx=5 still written exactly once with correct data; total latency +3.
- Three separate 3'b110 faults:
  - First two each trigger a scrub, with src = core 1.
  - Third sets core_disabled=3'b001, fault_count core0=3, no scrub.
  - A following 3'b101 sets fatal=1.
- voter_state=3'b000 or 3'b001 in IDLE: fatal=1, no core_hold. A 3'b011 pulse arriving during a scrub is ignored, and fault_count is unchanged.
- With SCRUB_VERIFY_EN: force the target RF to return a wrong readback for idx=7 twice. Expect one rewrite, then fatal=1, and the scrub completes through idx=31.
